// File: rtl/framing_pkg.sv
// framing_pkg -- shared constants and types for the framing RX drain block.
//   Register offsets and RX slot layout of the framing peripheral, the drain
//   FSM state encoding, the beat record carried through the skid buffer and a
//   helper computing the byte-enable mask of a frame's final word.
package framing_pkg;

  localparam int LEN_W = 11;                        // frame length field width

  localparam logic [14:0] REG_STATUS   = 15'h0830;  // [3:0] firstbuf, [7:4] nextbuf, [12] avail
  localparam logic [14:0] REG_LEN_BASE = 15'h0840;  // slot i length at +8*i
  localparam logic [14:0] RX_BASE      = 15'h4000;  // slot 0 data
  localparam logic [14:0] RX_STRIDE    = 15'h0800;  // bytes per slot
  localparam int          ST_AVAIL_BIT = 12;

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_POLL_WAIT, S_LEN, S_LEN_WAIT, S_DATA, S_RELEASE
  } state_e;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);  // 73

  // Final word keeps len%8 low bytes, or all eight when the frame is word aligned.
  function automatic logic [7:0] last_keep(input logic [LEN_W-1:0] len);
    if (len[2:0] == 3'd0) return 8'hFF;
    else                  return 8'hFF >> (4'd8 - {1'b0, len[2:0]});
  endfunction

endpackage

// File: rtl/framing_skid2.sv
// framing_skid2 -- two-entry FIFO that absorbs the one-cycle read latency of
// the framing data port against downstream back-pressure.
//   msoc_clk/rstn : clock, async active-low reset (contents cleared)
//   in_valid/in_data : push side; caller guarantees no push when full
//   out_valid/out_data/out_ready : pop side, head entry held until popped
//   count : current occupancy (0..2), used by the caller for read credits
module framing_skid2
  import framing_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic         msoc_clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              push, pop;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_q];
  assign count     = cnt_q;
  assign push      = in_valid && (cnt_q != 2'd2);
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = in_data;
    wr_d  = wr_q ^ push;
    rd_d  = rd_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      mem_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/framing_rx_drain.sv
// framing_rx_drain -- polls the framing RX status, reads each available frame
// out of its slot and streams it on an AXI-stream master, then releases the
// slot by advancing firstbuf.
//   msoc_clk/rstn            : clock, async active-low reset
//   enable                   : permits new polls (a frame in progress completes)
//   eth_irq                  : poll trigger when FRAMING_DRAIN_IRQ_EN is defined
//   core_lsu_* / ce_d / we_d / framing_sel / framing_rdata : framing bus
//                              (read data returns one cycle after the strobe)
//   m_t*                     : AXI-stream output, 64-bit beats, byte 0 in [7:0]
//   frames_drained/dropped   : saturating frame counters
// Build option: FRAMING_DRAIN_IRQ_EN -- poll on eth_irq instead of the
// free-running POLL_INTERVAL timer.
module framing_rx_drain
  import framing_pkg::*;
#(
  parameter int unsigned POLL_INTERVAL = 64,
  parameter int unsigned MAX_LEN       = 1536
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        eth_irq,
  output logic [14:0] core_lsu_addr,
  output logic [63:0] core_lsu_wdata,
  output logic [7:0]  core_lsu_be,
  output logic        ce_d,
  output logic        we_d,
  output logic        framing_sel,
  input  logic [63:0] framing_rdata,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [15:0] frames_drained,
  output logic [15:0] frames_dropped
);

  state_e           state_q, state_d;
  logic [3:0]       fb_q, fb_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       w_q, w_d;
  logic             drop_q, drop_d;
  logic             pend_q, pend_d;          // data read in flight, lands this cycle
  logic [7:0]       pend_keep_q, pend_keep_d;
  logic             pend_last_q, pend_last_d;
  logic [15:0]      drained_q, drained_d, dropped_q, dropped_d;

  logic             poll_fire;
  logic [1:0]       skid_cnt;
  logic             skid_pop;
  beat_t            skid_in, skid_out;
  logic [LEN_W-1:0] len_m1;
  logic [7:0]       last_w;
  logic [2:0]       occ;
  logic             can_issue, release_ok;
  logic [14:0]      data_addr;

`ifdef FRAMING_DRAIN_IRQ_EN
  assign poll_fire = eth_irq;
`else
  localparam int TMR_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             unused_eth_irq;

  assign unused_eth_irq = eth_irq;
  assign poll_fire      = (tmr_q == TMR_W'(POLL_INTERVAL - 1));
  assign tmr_d          = poll_fire ? '0 : tmr_q + 1'b1;

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`endif

  // Words are 0..ceil(len/8)-1; len is nonzero whenever DATA is entered.
  assign len_m1    = len_q - 1'b1;
  assign last_w    = len_m1[LEN_W-1:3];
  assign data_addr = RX_BASE + RX_STRIDE * {12'd0, fb_q[2:0]} + {4'd0, w_q, 3'd0};

  // A read issued now lands next cycle. Allow it only if the skid can hold
  // it even if the sink stalls from here on: entries after this cycle's pop
  // plus the read already in flight must leave a slot free.
  assign skid_pop   = m_tvalid && m_tready;
  assign occ        = {1'b0, skid_cnt} + {2'b0, pend_q} - {2'b0, skid_pop};
  assign can_issue  = (occ <= 3'd1);
  assign release_ok = !pend_q && (skid_cnt == 2'd0);

  // Bus strobes decode the current state: the DATA read must track skid
  // credits in the same cycle to sustain one word per cycle with two entries.
  always_comb begin
    state_d     = state_q;
    fb_d        = fb_q;
    len_d       = len_q;
    w_d         = w_q;
    drop_d      = drop_q;
    pend_d      = 1'b0;
    pend_keep_d = pend_keep_q;
    pend_last_d = 1'b0;
    drained_d   = drained_q;
    dropped_d   = dropped_q;
    ce_d           = 1'b0;
    we_d           = 1'b0;
    core_lsu_be    = 8'h00;
    core_lsu_addr  = 15'd0;
    core_lsu_wdata = 64'd0;
    case (state_q)
      S_IDLE: if (enable && poll_fire) state_d = S_POLL;
      S_POLL: begin
        ce_d          = 1'b1;
        core_lsu_be   = 8'hFF;
        core_lsu_addr = REG_STATUS;
        state_d       = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (framing_rdata[ST_AVAIL_BIT]) begin
          fb_d    = framing_rdata[3:0];
          state_d = S_LEN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN: begin
        ce_d          = 1'b1;
        core_lsu_be   = 8'hFF;
        core_lsu_addr = REG_LEN_BASE + {9'd0, fb_q[2:0], 3'd0};
        state_d       = S_LEN_WAIT;
      end
      S_LEN_WAIT: begin
        len_d = framing_rdata[LEN_W-1:0];
        w_d   = 8'd0;
        if (len_d == '0 || 32'(len_d) > MAX_LEN) begin
          drop_d    = 1'b1;
          dropped_d = (dropped_q != 16'hFFFF) ? dropped_q + 16'd1 : dropped_q;
          state_d   = S_RELEASE;
        end else begin
          drop_d  = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (can_issue) begin
          ce_d          = 1'b1;
          core_lsu_be   = 8'hFF;
          core_lsu_addr = data_addr;
          pend_d        = 1'b1;
          pend_last_d   = (w_q == last_w);
          pend_keep_d   = (w_q == last_w) ? last_keep(len_q) : 8'hFF;
          w_d           = w_q + 8'd1;
          if (w_q == last_w) state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Wait for the final beat to leave the skid before freeing the slot.
        if (release_ok) begin
          ce_d           = 1'b1;
          we_d           = 1'b1;
          core_lsu_be    = 8'h0F;
          core_lsu_addr  = REG_STATUS;
          core_lsu_wdata = {60'd0, fb_q + 4'd1};
          if (!drop_q)
            drained_d = (drained_q != 16'hFFFF) ? drained_q + 16'd1 : drained_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    framing_sel = ce_d;
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      fb_q        <= 4'd0;
      len_q       <= '0;
      w_q         <= 8'd0;
      drop_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_keep_q <= 8'd0;
      pend_last_q <= 1'b0;
      drained_q   <= 16'd0;
      dropped_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      fb_q        <= fb_d;
      len_q       <= len_d;
      w_q         <= w_d;
      drop_q      <= drop_d;
      pend_q      <= pend_d;
      pend_keep_q <= pend_keep_d;
      pend_last_q <= pend_last_d;
      drained_q   <= drained_d;
      dropped_q   <= dropped_d;
    end
  end

  assign skid_in = '{data: framing_rdata, keep: pend_keep_q, last: pend_last_q};

  framing_skid2 #(.W(BEAT_W)) u_skid (
    .msoc_clk  (msoc_clk),
    .rstn      (rstn),
    .in_valid  (pend_q),
    .in_data   (skid_in),
    .out_ready (m_tready),
    .out_valid (m_tvalid),
    .out_data  (skid_out),
    .count     (skid_cnt)
  );

  assign m_tdata        = skid_out.data;
  assign m_tkeep        = skid_out.keep;
  assign m_tlast        = skid_out.last && m_tvalid;
  assign frames_drained = drained_q;
  assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_framing_rx_drain.sv
// tb_framing_rx_drain -- directed bench for framing_rx_drain. A small framing
// model answers status/length/data reads one cycle after the strobe and
// records release writes; a sink captures accepted beats and watches payload
// stability during stalls.
module tb_framing_rx_drain;
  import framing_pkg::*;

  logic        clk = 1'b0, rstn = 1'b1, enable = 1'b0, eth_irq = 1'b0, m_tready = 1'b0;
  logic [14:0] addr;
  logic [63:0] wdata, rdata, m_tdata;
  logic [7:0]  be, m_tkeep;
  logic        ce, we, sel, m_tlast, m_tvalid;
  logic [15:0] drained, dropped;

  int tests = 0, fails = 0;
  int cyc = 0;

  // framing model state
  logic [3:0]  st_fb = 4'd0;
  int          frame_req = 0;
  int          wr_cnt = 0;
  logic [14:0] w_addr;
  logic [63:0] w_data;
  logic [7:0]  w_be;
  logic [2:0]  rd_slot;
  logic [10:0] len_mem [8];

  // sink capture
  logic [63:0] cap_data [256];
  logic [7:0]  cap_keep [256];
  logic        cap_last [256];
  int          cap_cyc  [256];
  int          n_cap = 0;
  int          stab_err = 0;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [63:0] pd = '0;
  logic [7:0]  pk = '0;

  framing_rx_drain #(.POLL_INTERVAL(16), .MAX_LEN(1536)) dut (
    .msoc_clk(clk), .rstn(rstn), .enable(enable), .eth_irq(eth_irq),
    .core_lsu_addr(addr), .core_lsu_wdata(wdata), .core_lsu_be(be),
    .ce_d(ce), .we_d(we), .framing_sel(sel), .framing_rdata(rdata),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .frames_drained(drained), .frames_dropped(dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slot contents: byte j of word w in slot s.
  function automatic logic [63:0] word(input int s, input int w);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(s * 37 + w * 8 + j + 1);
    return r;
  endfunction

  always @(posedge clk) begin
    if (ce && sel && we) begin
      wr_cnt <= wr_cnt + 1;
      w_addr <= addr;
      w_data <= wdata;
      w_be   <= be;
    end else if (ce && sel) begin
      if (addr == 15'h0830)
        rdata <= {51'd0, (frame_req != wr_cnt), 8'd0, st_fb};
      else if (addr >= 15'h0840 && addr < 15'h0880)
        rdata <= {53'd0, len_mem[addr[5:3]]};
      else if (addr[14]) begin
        rdata   <= word(int'(addr[13:11]), int'(addr[10:3]));
        rd_slot <= addr[13:11];
      end else
        rdata <= '0;
    end
  end

  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      cap_data[n_cap] <= m_tdata;
      cap_keep[n_cap] <= m_tkeep;
      cap_last[n_cap] <= m_tlast;
      cap_cyc[n_cap]  <= cyc;
      n_cap           <= n_cap + 1;
    end
    if (pv && !pr && (!m_tvalid || m_tdata !== pd || m_tkeep !== pk || m_tlast !== pl))
      stab_err <= stab_err + 1;
    pv <= m_tvalid; pr <= m_tready; pd <= m_tdata; pk <= m_tkeep; pl <= m_tlast;
  end

  // Offer one frame and drive the sink until its release write shows up.
  task automatic run_frame(input logic [3:0] fb, input logic [10:0] len,
                           input bit toggle, output bit done);
    int target;
    done   = 1'b0;
    target = wr_cnt + 1;
    st_fb  = fb;
    len_mem[fb[2:0]] = len;
    frame_req++;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      m_tready = toggle ? ~m_tready : 1'b1;
      @(negedge clk);
      if (wr_cnt == target) begin done = 1'b1; break; end
    end
    m_tready = 1'b1;
  endtask

  task automatic test_reset;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b want 0", m_tvalid); end
    tests++; if ({ce, we, sel} !== 3'b000) begin fails++; $display("FAIL reset_strobes got %b want 000", {ce, we, sel}); end
    tests++; if ({drained, dropped} !== 32'd0) begin fails++; $display("FAIL reset_counters got %h want 0", {drained, dropped}); end
    tests++; if (addr !== 15'd0 || wdata !== 64'd0) begin fails++; $display("FAIL reset_addr_data got %h/%h want 0", addr, wdata); end
    tests++; if (m_tkeep !== 8'd0 || m_tlast !== 1'b0 || m_tdata !== 64'd0) begin fails++; $display("FAIL reset_stream got %h/%b want 0", m_tkeep, m_tlast); end
    rstn = 1'b1; enable = 1'b1; m_tready = 1'b1;
  endtask

  task automatic test_len64;
    int base; bit done;
    base = n_cap;
    run_frame(4'd0, 11'd64, 1'b0, done);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL len64_timeout got no release write"); end
    tests++; if (n_cap - base != 8) begin fails++; $display("FAIL len64_beats got %0d want 8", n_cap - base); end
    for (int i = 0; i < 8 && i < n_cap - base; i++) begin
      tests++;
      if (cap_data[base+i] !== word(0, i) || cap_keep[base+i] !== 8'hFF || cap_last[base+i] !== (i == 7)) begin
        fails++; $display("FAIL len64_beat%0d got %h/%h/%b want %h/ff/%b", i, cap_data[base+i], cap_keep[base+i], cap_last[base+i], word(0, i), i == 7);
      end
    end
    tests++; if (cap_cyc[base+7] - cap_cyc[base] != 7) begin fails++; $display("FAIL len64_throughput got span %0d want 7", cap_cyc[base+7] - cap_cyc[base]); end
    tests++; if (w_addr !== 15'h0830 || w_data !== 64'd1 || w_be !== 8'h0F) begin fails++; $display("FAIL len64_release got %h/%h/%h want 0830/1/0f", w_addr, w_data, w_be); end
    tests++; if (drained !== 16'd1 || dropped !== 16'd0) begin fails++; $display("FAIL len64_counters got %0d/%0d want 1/0", drained, dropped); end
  endtask

  task automatic test_len61;
    int base; bit done;
    base = n_cap;
    run_frame(4'd1, 11'd61, 1'b0, done);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL len61_timeout got no release write"); end
    tests++; if (n_cap - base != 8) begin fails++; $display("FAIL len61_beats got %0d want 8", n_cap - base); end
    for (int i = 0; i < 8 && i < n_cap - base; i++) begin
      tests++;
      if (cap_data[base+i] !== word(1, i) || cap_keep[base+i] !== ((i == 7) ? 8'h1F : 8'hFF) || cap_last[base+i] !== (i == 7)) begin
        fails++; $display("FAIL len61_beat%0d got %h/%h/%b want %h", i, cap_data[base+i], cap_keep[base+i], cap_last[base+i], word(1, i));
      end
    end
    tests++; if (w_data !== 64'd2 || drained !== 16'd2) begin fails++; $display("FAIL len61_release got %h/%0d want 2/2", w_data, drained); end
  endtask

  task automatic test_backpressure;
    int base; bit done;
    base = n_cap;
    run_frame(4'd2, 11'd40, 1'b1, done);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL bp_timeout got no release write"); end
    tests++; if (n_cap - base != 5) begin fails++; $display("FAIL bp_beats got %0d want 5", n_cap - base); end
    for (int i = 0; i < 5 && i < n_cap - base; i++) begin
      tests++;
      if (cap_data[base+i] !== word(2, i) || cap_keep[base+i] !== 8'hFF || cap_last[base+i] !== (i == 4)) begin
        fails++; $display("FAIL bp_beat%0d got %h/%h/%b want %h", i, cap_data[base+i], cap_keep[base+i], cap_last[base+i], word(2, i));
      end
    end
    tests++; if (stab_err != 0) begin fails++; $display("FAIL bp_stable got %0d changes want 0", stab_err); end
    tests++; if (w_data !== 64'd3 || drained !== 16'd3) begin fails++; $display("FAIL bp_release got %h/%0d want 3/3", w_data, drained); end
  endtask

  task automatic test_drop;
    int base; bit done;
    base = n_cap;
    run_frame(4'd3, 11'd0, 1'b0, done);
    tests++; if (done !== 1'b1 || w_data !== 64'd4) begin fails++; $display("FAIL drop0_release got %b/%h want 1/4", done, w_data); end
    run_frame(4'd4, 11'd1600, 1'b0, done);
    tests++; if (done !== 1'b1 || w_data !== 64'd5) begin fails++; $display("FAIL drop1600_release got %b/%h want 1/5", done, w_data); end
    tests++; if (n_cap != base) begin fails++; $display("FAIL drop_beats got %0d want 0", n_cap - base); end
    tests++; if (dropped !== 16'd2 || drained !== 16'd3) begin fails++; $display("FAIL drop_counters got %0d/%0d want 2/3", dropped, drained); end
  endtask

  task automatic test_wrap;
    int base; bit done;
    base = n_cap;
    run_frame(4'd15, 11'd16, 1'b0, done);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL wrap_timeout got no release write"); end
    tests++; if (n_cap - base != 2) begin fails++; $display("FAIL wrap_beats got %0d want 2", n_cap - base); end
    for (int i = 0; i < 2 && i < n_cap - base; i++) begin
      tests++;
      if (cap_data[base+i] !== word(7, i)) begin
        fails++; $display("FAIL wrap_beat%0d got %h want %h", i, cap_data[base+i], word(7, i));
      end
    end
    tests++; if (rd_slot !== 3'd7) begin fails++; $display("FAIL wrap_slot got %0d want 7", rd_slot); end
    tests++; if (w_data !== 64'd0 || drained !== 16'd4) begin fails++; $display("FAIL wrap_release got %h/%0d want 0/4", w_data, drained); end
  endtask

  task automatic test_reset_mid;
    int base, wr0, n_rst; bit seen;
    base = n_cap; wr0 = wr_cnt; seen = 1'b0;
    st_fb = 4'd0; len_mem[0] = 11'd64; frame_req++;
    m_tready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_cap - base >= 3) begin seen = 1'b1; break; end
    end
    tests++; if (!seen) begin fails++; $display("FAIL rstmid_timeout got %0d beats want 3", n_cap - base); end
    rstn = 1'b0;
    #1;
    tests++; if (m_tvalid !== 1'b0 || ce !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid got %b/%b want 0/0", m_tvalid, ce); end
    n_rst = n_cap;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (dut.state_q !== S_IDLE) begin fails++; $display("FAIL rstmid_state got %0d want IDLE", dut.state_q); end
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    tests++; if (wr_cnt != wr0) begin fails++; $display("FAIL rstmid_nowrite got %0d writes want 0", wr_cnt - wr0); end
    tests++; if (n_cap != n_rst || m_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_nobeats got %0d/%b want 0/0", n_cap - n_rst, m_tvalid); end
    tests++; if (drained !== 16'd0 || dropped !== 16'd0) begin fails++; $display("FAIL rstmid_counters got %0d/%0d want 0/0", drained, dropped); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) len_mem[i] = 11'd0;
    test_reset;
    test_len64;
    test_len61;
    test_backpressure;
    test_drop;
    test_wrap;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
